// File: rtl/uart_bus_sequencer.sv
// Bus master that configures a UART after reset, then moves bytes from the tx stream to
// TXDATA and from RXDATA to the rx stream. Optional bus timeout: UART_SEQ_TIMEOUT_EN.
module uart_bus_sequencer #(
  parameter int unsigned            UART_ADDR_W = 3,
  parameter int unsigned            DATA_W      = 32,
  parameter int unsigned            DIV         = 868,
  parameter logic [UART_ADDR_W-1:0] A_SOFTRESET = UART_ADDR_W'(0),
  parameter logic [UART_ADDR_W-1:0] A_DIV       = UART_ADDR_W'(1),
  parameter logic [UART_ADDR_W-1:0] A_TXDATA    = UART_ADDR_W'(2),
  parameter logic [UART_ADDR_W-1:0] A_TXEN      = UART_ADDR_W'(3),
  parameter logic [UART_ADDR_W-1:0] A_TXREADY   = UART_ADDR_W'(4),
  parameter logic [UART_ADDR_W-1:0] A_RXDATA    = UART_ADDR_W'(5),
  parameter logic [UART_ADDR_W-1:0] A_RXEN      = UART_ADDR_W'(6),
  parameter logic [UART_ADDR_W-1:0] A_RXREADY   = UART_ADDR_W'(7),
  parameter int unsigned            TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   uart_valid,
  output logic [UART_ADDR_W-1:0] uart_addr,
  output logic [DATA_W-1:0]      uart_wdata,
  output logic                   uart_wstrb,
  input  logic [DATA_W-1:0]      uart_rdata,
  input  logic                   uart_ready,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   init_done,
  output logic                   err
);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4,
    S_IDLE, S_RD_RXRDY, S_RD_RXDATA, S_RD_TXRDY, S_WR_TX
  } state_e;

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [UART_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   wstrb_q, wstrb_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   init_done_q, init_done_d;
  logic                   toggle_q, toggle_d;
  logic [7:0]             tx_byte_q, tx_byte_d;

  logic [UART_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   req_wstrb;
  logic                   acc_done;
  logic                   timeout;
  logic                   rx_ok;
  logic                   tx_ok;

  logic unused_rdata;
  assign unused_rdata = ^uart_rdata[DATA_W-1:8];

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A ready in the final cycle wins over the timeout.
  assign timeout = valid_q && !uart_ready && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    err_d = err_q | timeout;
    cnt_d = (valid_q && !uart_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == 0);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  // Bus request belonging to the current state.
  always_comb begin
    req_addr  = A_SOFTRESET;
    req_wdata = '0;
    req_wstrb = 1'b0;
    case (state_q)
      S_INIT0:     begin req_addr = A_SOFTRESET; req_wdata = DATA_W'(1);   req_wstrb = 1'b1; end
      S_INIT1:     begin req_addr = A_SOFTRESET; req_wdata = '0;           req_wstrb = 1'b1; end
      S_INIT2:     begin req_addr = A_DIV;       req_wdata = DATA_W'(DIV); req_wstrb = 1'b1; end
      S_INIT3:     begin req_addr = A_TXEN;      req_wdata = DATA_W'(1);   req_wstrb = 1'b1; end
      S_INIT4:     begin req_addr = A_RXEN;      req_wdata = DATA_W'(1);   req_wstrb = 1'b1; end
      S_RD_RXRDY:  req_addr = A_RXREADY;
      S_RD_RXDATA: req_addr = A_RXDATA;
      S_RD_TXRDY:  req_addr = A_TXREADY;
      S_WR_TX:     begin req_addr = A_TXDATA; req_wdata = DATA_W'(tx_byte_q); req_wstrb = 1'b1; end
      default:     ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tx_ready_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    init_done_d = init_done_q;
    toggle_d    = toggle_q;
    tx_byte_d   = tx_byte_q;
    acc_done    = valid_q && uart_ready;
    rx_ok       = !rx_valid_q;
    // tx_ready is registered, so the producer only sees it one cycle late; the byte still
    // on tx_data during that cycle is the one just written and must not be taken again.
    tx_ok       = tx_valid && !tx_ready_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (timeout) begin
      valid_d = 1'b0;
      state_d = init_done_q ? S_IDLE : S_INIT0;
    end else if (acc_done) begin
      valid_d = 1'b0;
      case (state_q)
        S_INIT0: state_d = S_INIT1;
        S_INIT1: state_d = S_INIT2;
        S_INIT2: state_d = S_INIT3;
        S_INIT3: state_d = S_INIT4;
        S_INIT4: begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
        S_RD_RXRDY:  state_d = uart_rdata[0] ? S_RD_RXDATA : S_IDLE;
        S_RD_RXDATA: begin
          rx_data_d  = uart_rdata[7:0];
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
        S_RD_TXRDY:  state_d = uart_rdata[0] ? S_WR_TX : S_IDLE;
        S_WR_TX: begin
          tx_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (!valid_q) begin
      if (state_q == S_IDLE) begin
        // toggle_q = 0 prefers the RX slot; a skipped slot hands over to the other one.
        if (rx_ok && (!toggle_q || !tx_ok)) begin
          state_d  = S_RD_RXRDY;
          toggle_d = ~toggle_q;
        end else if (tx_ok) begin
          state_d   = S_RD_TXRDY;
          tx_byte_d = tx_data;
          toggle_d  = ~toggle_q;
        end
      end else begin
        valid_d = 1'b1;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      toggle_q    <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      toggle_q    <= toggle_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  assign uart_valid = valid_q;
  assign uart_addr  = addr_q;
  assign uart_wdata = wdata_q;
  assign uart_wstrb = wstrb_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Bench for uart_bus_sequencer: a UART register slave model logs every access; boot and
// re-init traffic is compared against a record table, streaming corners are hand sequenced.
module tb_uart_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_valid;
  logic [2:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        init_done;
  logic        err;

  uart_bus_sequencer #(.UART_ADDR_W(3), .DATA_W(32), .DIV(868), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  addr;
    logic        wstrb;
    logic [31:0] wdata;
    logic        idone;
  } rec_t;

  rec_t        acc_log[$];
  logic [31:0] tx_log[$];
  logic [7:0]  rx_src[$];
  logic [7:0]  rx_got[$];
  bit          slave_en, rx_always, tx_rdy, stall_wr;
  logic [7:0]  rx_cnt;

  // UART register slave: acks on the second valid cycle; logs each completed access.
  initial begin : slave
    int unsigned wait_cnt;
    logic [2:0]  held_addr;
    wait_cnt   = 0;
    held_addr  = '0;
    uart_ready = 1'b0;
    uart_rdata = '0;
    forever begin
      @(negedge clk);
      if (uart_ready) begin
        uart_ready = 1'b0;
        uart_rdata = '0;
        check("bus_gap", uart_valid, 0);
      end else if (uart_valid && slave_en && !reset) begin
        if (wait_cnt == 0) held_addr = uart_addr;
        else check("addr_stable", uart_addr, held_addr);
        wait_cnt++;
        if (wait_cnt > 1 && !(stall_wr && uart_addr == 3'd2 && uart_wstrb)) begin
          acc_log.push_back('{uart_addr, uart_wstrb, uart_wdata, init_done});
          uart_rdata = '0;
          case (uart_addr)
            3'd7: uart_rdata = (rx_always || rx_src.size() != 0) ? 32'd1 : 32'd0;
            3'd5: begin
              if (rx_always) begin
                uart_rdata = {24'd0, rx_cnt};
                rx_cnt++;
              end else if (rx_src.size() != 0) begin
                uart_rdata = {24'd0, rx_src.pop_front()};
              end
            end
            3'd4: uart_rdata = {31'd0, tx_rdy};
            3'd2: if (uart_wstrb) tx_log.push_back(uart_wdata);
            default: ;
          endcase
          uart_ready = 1'b1;
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Expected access records: boot writes, then the first RX poll and RX data read.
  rec_t tbl[7];

  task automatic check_log(input int base, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (acc_log.size() > base + i) begin
        check({tag, "_addr"}, acc_log[base+i].addr, tbl[i].addr);
        check({tag, "_wstrb"}, acc_log[base+i].wstrb, tbl[i].wstrb);
        check({tag, "_init_done"}, acc_log[base+i].idone, tbl[i].idone);
        if (tbl[i].wstrb) check({tag, "_wdata"}, acc_log[base+i].wdata, tbl[i].wdata);
      end else begin
        check({tag, "_count"}, acc_log.size(), base + n);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, n0, base, idx, pulses, bad, natt, viol, first;
    logic [2:0]  prev;
    logic [7:0]  tx_bytes[3];
    logic [7:0]  txn;

    tbl[0] = '{3'd0, 1'b1, 32'd1,   1'b0};
    tbl[1] = '{3'd0, 1'b1, 32'd0,   1'b0};
    tbl[2] = '{3'd1, 1'b1, 32'd868, 1'b0};
    tbl[3] = '{3'd3, 1'b1, 32'd1,   1'b0};
    tbl[4] = '{3'd6, 1'b1, 32'd1,   1'b0};
    tbl[5] = '{3'd7, 1'b0, 32'd0,   1'b1};
    tbl[6] = '{3'd5, 1'b0, 32'd0,   1'b1};
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    slave_en = 1'b1; rx_always = 1'b0; tx_rdy = 1'b0; stall_wr = 1'b0; rx_cnt = '0;
    cycles(3);
    check("rst_valid", uart_valid, 0);
    check("rst_addr", uart_addr, 0);
    check("rst_wdata", uart_wdata, 0);
    check("rst_wstrb", uart_wstrb, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err", err, 0);

    // Boot, then one RX byte 0x41 held with rx_ready low.
    rx_src.push_back(8'h41);
    reset = 1'b0;
    n = 0;
    while (!rx_valid && n < 400) begin @(negedge clk); n++; end
    check("rx_arrive", rx_valid, 1);
    check("rx_data", rx_data, 8'h41);
    check_log(0, 7, "boot");
    n0 = acc_log.size();
    check("boot_access_count", n0, 7);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rx_valid || rx_data !== 8'h41) bad++;
    end
    check("rx_hold", bad, 0);
    check("rx_hold_no_poll", acc_log.size(), n0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_clear", rx_valid, 0);
    n = 0;
    while (acc_log.size() <= n0 && n < 40) begin @(negedge clk); n++; end
    if (acc_log.size() > n0) check("rx_poll_resume", acc_log[n0].addr, 7);
    else check("rx_poll_resume_count", acc_log.size(), n0 + 1);

    // TX: three bytes, TXREADY low for 20 cycles.
    idx = 0; pulses = 0;
    tx_data = tx_bytes[0]; tx_valid = 1'b1;
    for (int c = 0; c < 600 && idx < 3; c++) begin
      @(negedge clk);
      if (c == 20) begin
        check("tx_blocked", tx_log.size(), 0);
        tx_rdy = 1'b1;
      end
      if (tx_ready) begin
        pulses++; idx++;
        if (idx < 3) tx_data = tx_bytes[idx];
        else tx_valid = 1'b0;
      end
    end
    repeat (10) begin @(negedge clk); if (tx_ready) pulses++; end
    check("tx_pulses", pulses, 3);
    check("tx_writes", tx_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (tx_log.size() > i) check("tx_byte", tx_log[i], {24'd0, tx_bytes[i]});

    // Reset during a stalled TXDATA write.
    stall_wr = 1'b1; tx_data = 8'h5a; tx_valid = 1'b1;
    n = 0;
    while (!(uart_valid && uart_addr == 3'd2 && uart_wstrb) && n < 200) begin
      @(negedge clk); n++;
    end
    cycles(3);
    check("wr_tx_held", {uart_valid, uart_addr}, {1'b1, 3'd2});
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_drops_valid", uart_valid, 0);
    bad = 0;
    repeat (2) begin @(negedge clk); if (tx_ready) bad++; end
    check("reset_no_tx_ready", bad, 0);
    check("reset_init_done", init_done, 0);

    // Re-init with RX and TX both pending continuously.
    stall_wr = 1'b0; rx_always = 1'b1; rx_cnt = '0; tx_rdy = 1'b1;
    txn = 8'h80; tx_data = txn; tx_valid = 1'b1;
    tx_log.delete();
    base = acc_log.size();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx_ready) begin txn++; tx_data = txn; end
      if (rx_ready) rx_ready = 1'b0;
      else if (rx_valid) begin rx_got.push_back(rx_data); rx_ready = 1'b1; end
    end
    tx_valid = 1'b0; rx_always = 1'b0; rx_ready = 1'b0;
    cycles(20);
    check_log(base, 6, "reinit");
    natt = 0; viol = 0; first = 0; prev = '0;
    for (int i = base; i < acc_log.size(); i++) begin
      if (acc_log[i].idone && (acc_log[i].addr == 3'd7 || acc_log[i].addr == 3'd4)) begin
        if (natt == 0) first = acc_log[i].addr;
        else if (acc_log[i].addr == prev) viol++;
        prev = acc_log[i].addr;
        nat_inc: natt++;
      end
    end
    check("alt_first_rx", first, 7);
    check("alt_violations", viol, 0);
    check("alt_attempts", natt >= 10, 1);
    bad = 0;
    for (int i = 0; i < rx_got.size(); i++) if (rx_got[i] !== 8'(i)) bad++;
    check("rx_stream_order", bad, 0);
    check("rx_stream_count", rx_got.size() >= 5, 1);
    bad = 0;
    for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] !== 32'(8'h80 + i)) bad++;
    check("tx_stream_order", bad, 0);
    check("tx_stream_count", tx_log.size() >= 5, 1);
    check("err_clear", err, 0);

`ifdef UART_SEQ_TIMEOUT_EN
    // Slave stops answering: the first init write must time out after 16 cycles.
    slave_en = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    n = 0;
    while (!uart_valid && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (uart_valid && n < 100) begin @(negedge clk); n++; end
    check("timeout_valid_cycles", n, 16);
    check("timeout_err", err, 1);
    check("timeout_init_done", init_done, 0);
    n = 0;
    while (!uart_valid && n < 20) begin @(negedge clk); n++; end
    check("timeout_restart", {uart_valid, uart_addr, uart_wstrb, uart_wdata},
          {1'b1, 3'd0, 1'b1, 32'd1});
`else
    cycles(5);
    check("err_tied_low", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
